// File: rtl/wolfram_ca.sv
// wolfram_ca: one-dimensional elementary cellular automaton engine.
// A run loads a seed and then computes a latched number of generations
// under a latched 8-bit Wolfram rule, one generation per clock cycle.
//
// Build option:
//   WOLFRAM_CA_WRAP_EN  defined   -> toroidal boundary (edge cells see each other)
//                       undefined -> fixed-zero boundary
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   start      run request, sampled only in IDLE
//   rule       rule number; bit k is the next cell value for neighbourhood k
//   seed       initial generation loaded on start
//   steps      number of generations to compute
//   hold       freezes evolution while high
//   abort      ends a run early, no done pulse
//   cells      current generation (registered)
//   gen_count  generations computed in the current or last run (registered)
//   busy       high while running (registered)
//   done       one-cycle completion pulse (registered)
module wolfram_ca #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STEP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rule,
    input  logic [WIDTH-1:0]  seed,
    input  logic [STEP_W-1:0] steps,
    input  logic              hold,
    input  logic              abort,
    output logic [WIDTH-1:0]  cells,
    output logic [STEP_W-1:0] gen_count,
    output logic              busy,
    output logic              done
);

    localparam int unsigned EXT_W = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        rule_l;
    logic [7:0]        rule_nxt;
    logic [STEP_W-1:0] steps_l;
    logic [STEP_W-1:0] steps_nxt;
    logic [WIDTH-1:0]  cells_nxt;
    logic [STEP_W-1:0] gen_nxt;
    logic [STEP_W-1:0] gen_inc;
    logic [EXT_W-1:0]  ext;
    logic [WIDTH-1:0]  gen_next;

    // Cells padded with the boundary values: ext[0] is c[-1], ext[WIDTH+1] is c[WIDTH].
    always_comb begin
`ifdef WOLFRAM_CA_WRAP_EN
        ext = {cells[0], cells, cells[WIDTH-1]};
`else
        ext = {1'b0, cells, 1'b0};
`endif
    end

    // Next generation, all cells in parallel; ext[i+:3] is {c[i+1], c[i], c[i-1]}.
    always_comb begin
        gen_next = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            gen_next[i] = rule_l[ext[i +: 3]];
        end
    end

    assign gen_inc = gen_count + STEP_W'(1);

    // Next-state and datapath update selection.
    always_comb begin
        state_nxt = state;
        rule_nxt  = rule_l;
        steps_nxt = steps_l;
        cells_nxt = cells;
        gen_nxt   = gen_count;
        case (state)
            IDLE: begin
                if (start) begin
                    rule_nxt  = rule;
                    steps_nxt = steps;
                    cells_nxt = seed;
                    gen_nxt   = '0;
                    state_nxt = (steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort wins over hold and over completion in the same cycle.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!hold) begin
                    cells_nxt = gen_next;
                    gen_nxt   = gen_inc;
                    if (gen_inc == steps_l) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rule_l    <= '0;
            steps_l   <= '0;
            cells     <= '0;
            gen_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rule_l    <= rule_nxt;
            steps_l   <= steps_nxt;
            cells     <= cells_nxt;
            gen_count <= gen_nxt;
            busy      <= (state_nxt == RUN);
            done      <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_wolfram_ca.sv
// tb_wolfram_ca: self-checking bench for wolfram_ca (WIDTH=8).
// Expected generations come from a per-cell reference that evaluates the rule
// table directly; latency and pulse counts come from the run length arithmetic.
module tb_wolfram_ca;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = 16;
`ifdef WOLFRAM_CA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    rule;
    logic [W-1:0]  seed;
    logic [SW-1:0] steps;
    logic          hold;
    logic          abort;
    logic [W-1:0]  cells;
    logic [SW-1:0] gen_count;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fails  = 0;

    wolfram_ca #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .rule(rule), .seed(seed),
        .steps(steps), .hold(hold), .abort(abort), .cells(cells),
        .gen_count(gen_count), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One generation of the reference automaton.
    function automatic logic [W-1:0] model_next(input logic [W-1:0] c, input logic [7:0] r);
        logic [W-1:0] out;
        int left, mid, right, code;
        out = '0;
        for (int i = 0; i < int'(W); i++) begin
            mid = int'(c[i]);
            if (i == 0) right = WRAP ? int'(c[W-1]) : 0;
            else        right = int'(c[i-1]);
            if (i == int'(W) - 1) left = WRAP ? int'(c[0]) : 0;
            else                  left = int'(c[i+1]);
            code = left * 4 + mid * 2 + right;
            out[i] = ((int'(r) >> code) & 1) == 1;
        end
        return out;
    endfunction

    function automatic logic [W-1:0] model_run(input logic [W-1:0] s, input logic [7:0] r, input int n);
        logic [W-1:0] c;
        c = s;
        for (int g = 0; g < n; g++) c = model_next(c, r);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
    endtask

    // Runs one transaction; hold is high for hl edges starting at edge hs (edge 1 samples start).
    task automatic run_case(input string name, input logic [7:0] r, input logic [W-1:0] s,
                            input int n, input int hs, input int hl,
                            input logic [W-1:0] exp_cells);
        int exp_lat, done_edge, done_cnt, busy_cnt;
        exp_lat   = n + 1 + hl;
        done_edge = 0;
        done_cnt  = 0;
        busy_cnt  = 0;
        rule  = r;
        seed  = s;
        steps = SW'(n);
        start = 1'b1;
        abort = 1'b0;
        for (int e = 1; e <= exp_lat + 3; e++) begin
            hold = (e >= hs) && (e < hs + hl);
            tick();
            if (done) begin
                done_cnt++;
                if (done_edge == 0) done_edge = e;
            end
            if (busy) busy_cnt++;
            // Stray start/data changes while running must be ignored.
            start = (e + 1 <= exp_lat && n > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            rule  = 8'($urandom);
            seed  = W'($urandom);
            steps = SW'($urandom);
        end
        hold = 1'b0;
        n_checks++;
        if (done_edge !== exp_lat) begin
            n_fails++;
            $display("FAIL %s done_edge: got %0d expected %0d", name, done_edge, exp_lat);
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fails++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end
        n_checks++;
        if (busy_cnt !== n + hl) begin
            n_fails++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, n + hl);
        end
        n_checks++;
        if (cells !== exp_cells) begin
            n_fails++;
            $display("FAIL %s cells: got %h expected %h", name, cells, exp_cells);
        end
        n_checks++;
        if (gen_count !== SW'(n)) begin
            n_fails++;
            $display("FAIL %s gen_count: got %0d expected %0d", name, gen_count, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        rule  = 8'hFF;
        seed  = 8'hFF;
        steps = 16'd0;
        hold  = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({cells, gen_count, busy, done} !== {8'h00, 16'd0, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_state: got cells=%h gen=%0d busy=%b done=%b expected 00/0/0/0",
                     cells, gen_count, busy, done);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_directed();
        run_case("rule90_s1",  8'd90,  8'h10, 1, 2, 0, 8'h28);
        run_case("rule90_s2",  8'd90,  8'h44 ^ 8'h44 ^ 8'h10, 2, 2, 0, 8'h44);
        run_case("boundary",   8'd90,  8'h01, 1, 2, 0, WRAP ? 8'h82 : 8'h02);
        run_case("hold_mid",   8'hCC,  8'hA5, 5, 3, 3, 8'hA5);
        run_case("steps_zero", 8'd90,  8'h5A, 0, 2, 0, 8'h5A);
    endtask

    task automatic test_random();
        logic [7:0]   r;
        logic [W-1:0] s;
        int n, hs, hl;
        for (int k = 0; k < 24; k++) begin
            r  = 8'($urandom);
            s  = W'($urandom);
            n  = $urandom_range(0, 20);
            hl = (n > 0) ? $urandom_range(0, 4) : 0;
            hs = (n > 0) ? $urandom_range(2, n + 1) : 2;
            run_case($sformatf("rand%0d", k), r, s, n, hs, hl, model_run(s, r, n));
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] s;
        int seen_done;
        s = W'($urandom);
        rule  = 8'hFF;
        seed  = s;
        steps = 16'd100;
        start = 1'b1;
        tick();
        // Restart attempts with steps=0 while running must not disturb the run.
        for (int e = 2; e <= 4; e++) begin
            start = 1'b1;
            steps = 16'd0;
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (gen_count !== 16'd3) begin
            n_fails++;
            $display("FAIL abort_pre_gen: got %0d expected 3", gen_count);
        end
        abort = 1'b1;
        hold  = 1'b1;
        tick();
        abort = 1'b0;
        hold  = 1'b0;
        seen_done = 0;
        for (int e = 0; e < 5; e++) begin
            if (done || busy) seen_done++;
            tick();
        end
        n_checks++;
        if ({cells, gen_count, 32'(seen_done)} !== {model_run(s, 8'hFF, 3), 16'd3, 32'd0}) begin
            n_fails++;
            $display("FAIL abort_state: got cells=%h gen=%0d done/busy=%0d expected %h/3/0",
                     cells, gen_count, seen_done, model_run(s, 8'hFF, 3));
        end
        // Abort on the cycle that would have completed the run.
        rule  = 8'd90;
        seed  = 8'h10;
        steps = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        seen_done = 0;
        for (int e = 0; e < 5; e++) begin
            if (done || busy) seen_done++;
            tick();
        end
        n_checks++;
        if ({cells, gen_count, 32'(seen_done)} !== {8'h28, 16'd1, 32'd0}) begin
            n_fails++;
            $display("FAIL abort_at_end: got cells=%h gen=%0d done/busy=%0d expected 28/1/0",
                     cells, gen_count, seen_done);
        end
    endtask

    task automatic test_reset_midrun();
        int activity;
        rule  = 8'hFF;
        seed  = 8'h3C;
        steps = 16'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 5; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({cells, gen_count, busy, done} !== {8'h00, 16'd0, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_midrun: got cells=%h gen=%0d busy=%b done=%b expected 00/0/0/0",
                     cells, gen_count, busy, done);
        end
        activity = 0;
        for (int e = 0; e < 60; e++) begin
            if (done || busy || cells != 8'h00) activity++;
            tick();
        end
        n_checks++;
        if (activity !== 0) begin
            n_fails++;
            $display("FAIL reset_idle: got %0d active cycles expected 0", activity);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        rule  = '0;
        seed  = '0;
        steps = '0;
        test_reset();
        test_directed();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/wolfram_ca.md
WOLFRAM_CA -- requirements
Module: wolfram_ca

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the number of cells (legal range 3..64).
REQ-002 SHALL have parameter STEP_W, default 16, giving the width of the step counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a run; sampled only in IDLE.
REQ-006 SHALL have port rule, input, 8 bits: rule number; bit k is the next value for neighbourhood code k.
REQ-007 SHALL have port seed, input, WIDTH bits: initial generation.
REQ-008 SHALL have port steps, input, STEP_W bits: number of generations to compute.
REQ-009 SHALL have port hold, input, 1 bit: freeze evolution while high.
REQ-010 SHALL have port abort, input, 1 bit: terminate the run early.
REQ-011 SHALL have port cells, output, WIDTH bits: current generation, registered.
REQ-012 SHALL have port gen_count, output, STEP_W bits: generations computed in the current or last run.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 In IDLE, when start=1 at edge T, SHALL latch rule and steps internally, load cells<=seed and gen_count<=0, and go to RUN (or to DONE if steps==0).
REQ-017 SHALL compute the neighbourhood code of cell i as {c[i+1], c[i], c[i-1]}, MSB first, and set the next c[i] to rule_latched[code].
REQ-018 SHALL compute all cells in parallel, one generation per RUN cycle with hold=0, and increment gen_count by 1 per generation.
REQ-019 In RUN, when gen_count reaches steps_latched after an update, SHALL go to DONE in the same edge; no further generations are computed.
REQ-020 SHALL hold done=1 exactly for the one cycle spent in DONE, then return to IDLE; busy=0 in IDLE and DONE.
REQ-021 Latency with no hold: done SHALL be high in the cycle beginning steps+1 edges after the start edge (one edge after start for steps==0).
REQ-022 With hold=1 in RUN, SHALL leave cells and gen_count unchanged; latency extends by one cycle per held cycle.
REQ-023 With abort=1 in RUN, SHALL go to IDLE without pulsing done, keeping cells and gen_count; abort takes priority over hold and over completion in the same cycle.
REQ-024 SHALL ignore start outside IDLE, and SHALL ignore rule, seed and steps changes during a run.
REQ-025 SHALL let cells and gen_count hold their values in IDLE between runs.

Reset
REQ-026 reset=1 at any edge SHALL force IDLE, cells=0, gen_count=0, busy=0, done=0 and latched rule=0, overriding all other inputs, including mid-run.

Configuration
REQ-027 With macro WOLFRAM_CA_WRAP_EN defined, boundaries SHALL be toroidal: c[WIDTH]=c[0] and c[-1]=c[WIDTH-1].
REQ-028 Without WOLFRAM_CA_WRAP_EN, boundaries SHALL be fixed zero: c[WIDTH]=0 and c[-1]=0.

Verification
REQ-029 WIDTH=8, no wrap, rule=8'd90, seed=8'h10, steps=1 -> cells=8'h28, gen_count=1, done one cycle 2 edges after start.
REQ-030 Same as REQ-029 with steps=2 -> cells=8'h44, gen_count=2; busy high for exactly 2 cycles.
REQ-031 rule=8'd90, seed=8'h01, steps=1 -> cells=8'h02 without the macro; cells=8'h82 with WOLFRAM_CA_WRAP_EN.
REQ-032 rule=8'hCC, seed=8'hA5, steps=5, with hold high for 3 cycles mid-run -> cells=8'hA5, gen_count=5, done 9 edges after start.
REQ-033 steps=0 -> cells=seed, gen_count=0, done on the first cycle after start, busy never high.
REQ-034 rule=8'hFF, steps=100: abort at gen_count=3 -> IDLE with no done; separately, reset mid-run -> cells=0, FSM in IDLE, busy=0; start re-asserted during RUN -> ignored.
